// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the fetch/data memory bus arbiter.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUS_I,
        BUS_D
    } arb_state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } owner_t;

    localparam logic [3:0] BYTE_ALL = 4'hF;

endpackage

// File: rtl/mem_bus_arbiter_timeout.sv
// Stall-cycle counter for a bus transaction; flags the cycle whose edge completes the limit.
module bus_timeout_counter
    import mem_bus_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] limit,
    output logic             expired
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    // High during the stall cycle whose closing edge brings the count to the limit.
    assign expired = enable && (count == limit - CNT_W'(1));

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the fetch (I) and load/store (D) ports onto one Avalon-MM master.
// Build option: define ARB_ROUND_ROBIN_EN for last-owner fairness on simultaneous requests.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 0,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [3:0]        d_be,
    output logic              d_ack,
    output logic [31:0]       d_rdata,
    output logic [ADDR_W-1:0] address,
    output logic              read,
    output logic              write,
    output logic [31:0]       writedata,
    output logic [3:0]        byteenable,
    input  logic              waitrequest,
    input  logic [31:0]       readdata,
    output logic              busy,
    output logic              err
);

    arb_state_t        state, state_nx;
    logic [ADDR_W-1:0] address_nx;
    logic [31:0]       writedata_nx, i_rdata_nx, d_rdata_nx;
    logic [3:0]        byteenable_nx;
    logic              read_nx, write_nx, i_ack_nx, d_ack_nx, err_nx;
    logic              i_elig, d_elig, d_wins_tie, pick_d, pick_i, tmo_expired;

    // A port whose ack is showing this cycle is still finishing; ignore its req.
    assign i_elig = i_req && !i_ack;
    assign d_elig = d_req && !d_ack;
    assign pick_d = d_elig && (!i_elig || d_wins_tie);
    assign pick_i = i_elig && !pick_d;
    assign busy   = (state != IDLE);

`ifdef ARB_ROUND_ROBIN_EN
    owner_t last_owner;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_owner <= OWN_I;
        end else if (state == IDLE && pick_d) begin
            last_owner <= OWN_D;
        end else if (state == IDLE && pick_i) begin
            last_owner <= OWN_I;
        end
    end

    assign d_wins_tie = (last_owner == OWN_I);
`else
    assign d_wins_tie = 1'b1;
`endif

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_timeout
            localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
            logic [TMO_W-1:0] limit;
            logic             tmo_clear, tmo_enable;

            assign limit      = TMO_W'(TIMEOUT_CYCLES);
            assign tmo_clear  = (state == IDLE);
            assign tmo_enable = (state != IDLE) && waitrequest;

            bus_timeout_counter #(.CNT_W(TMO_W)) u_timeout (
                .clk     (clk),
                .reset   (reset),
                .clear   (tmo_clear),
                .enable  (tmo_enable),
                .limit   (limit),
                .expired (tmo_expired)
            );
        end else begin : g_no_timeout
            assign tmo_expired = 1'b0;
        end
    endgenerate

    always_comb begin
        state_nx      = state;
        address_nx    = address;
        writedata_nx  = writedata;
        byteenable_nx = byteenable;
        read_nx       = read;
        write_nx      = write;
        i_ack_nx      = 1'b0;
        d_ack_nx      = 1'b0;
        i_rdata_nx    = i_rdata;
        d_rdata_nx    = d_rdata;
        err_nx        = err;

        case (state)
            IDLE: begin
                if (pick_d) begin
                    state_nx      = BUS_D;
                    address_nx    = d_addr;
                    writedata_nx  = d_wdata;
                    byteenable_nx = d_be;
                    read_nx       = !d_we;
                    write_nx      = d_we;
                end else if (pick_i) begin
                    state_nx      = BUS_I;
                    address_nx    = i_addr;
                    byteenable_nx = BYTE_ALL;
                    read_nx       = 1'b1;
                    write_nx      = 1'b0;
                end
            end

            BUS_I, BUS_D: begin
                if (!waitrequest || tmo_expired) begin
                    state_nx = IDLE;
                    read_nx  = 1'b0;
                    write_nx = 1'b0;
                    if (state == BUS_I) begin
                        i_ack_nx = 1'b1;
                    end else begin
                        d_ack_nx = 1'b1;
                    end
                    // An aborted transfer returns the previous word untouched.
                    if (!waitrequest) begin
                        if (state == BUS_I) begin
                            i_rdata_nx = readdata;
                        end else if (read) begin
                            d_rdata_nx = readdata;
                        end
                    end else begin
                        err_nx = 1'b1;
                    end
                end
            end

            default: begin
                state_nx = IDLE;
                read_nx  = 1'b0;
                write_nx = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            address    <= '0;
            writedata  <= '0;
            byteenable <= '0;
            read       <= 1'b0;
            write      <= 1'b0;
            i_ack      <= 1'b0;
            d_ack      <= 1'b0;
            i_rdata    <= '0;
            d_rdata    <= '0;
            err        <= 1'b0;
        end else begin
            state      <= state_nx;
            address    <= address_nx;
            writedata  <= writedata_nx;
            byteenable <= byteenable_nx;
            read       <= read_nx;
            write      <= write_nx;
            i_ack      <= i_ack_nx;
            d_ack      <= d_ack_nx;
            i_rdata    <= i_rdata_nx;
            d_rdata    <= d_rdata_nx;
            err        <= err_nx;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus a randomized run against a transaction model.
module tb_mem_bus_arbiter;

    localparam int ADDR_W = 32;
    localparam int TMO    = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              i_req, i_ack, d_req, d_we, d_ack;
    logic [ADDR_W-1:0] i_addr, d_addr, address;
    logic [31:0]       i_rdata, d_wdata, d_rdata, writedata, readdata;
    logic [3:0]        d_be, byteenable;
    logic              read, write, waitrequest, busy, err;

    int checks = 0;
    int errors = 0;

    mem_bus_arbiter #(.TIMEOUT_CYCLES(TMO), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .address(address), .read(read), .write(write), .writedata(writedata),
        .byteenable(byteenable), .waitrequest(waitrequest), .readdata(readdata),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; i_req = 1'b0; d_req = 1'b0; i_addr = '0; d_we = 1'b0; d_addr = '0;
        d_wdata = '0; d_be = '0; waitrequest = 1'b0; readdata = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({read, write, i_ack, d_ack, busy, err} !== 6'b0) begin
            errors++; $display("FAIL reset_ctrl got %b exp 000000", {read, write, i_ack, d_ack, busy, err});
        end
        checks++;
        if (address !== 0 || writedata !== 0 || byteenable !== 0 || i_rdata !== 0 || d_rdata !== 0) begin
            errors++; $display("FAIL reset_data got addr=%h wd=%h be=%h ir=%h dr=%h exp all 0",
                               address, writedata, byteenable, i_rdata, d_rdata);
        end
    endtask

    task automatic test_fetch();
        i_addr = 32'hBFC00000; readdata = 32'h24020005; waitrequest = 1'b0; i_req = 1'b1;
        step();
        checks++;
        if (read !== 1'b1 || write !== 1'b0 || address !== 32'hBFC00000 || byteenable !== 4'hF || i_ack !== 1'b0) begin
            errors++; $display("FAIL fetch_bus got rd=%b wr=%b addr=%h be=%h ack=%b exp 1 0 bfc00000 f 0",
                               read, write, address, byteenable, i_ack);
        end
        step();
        checks++;
        if (i_ack !== 1'b1 || i_rdata !== 32'h24020005 || read !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL fetch_ack got ack=%b rdata=%h rd=%b busy=%b exp 1 24020005 0 0",
                               i_ack, i_rdata, read, busy);
        end
        i_req = 1'b0;
        step();
        checks++;
        if (i_ack !== 1'b0 || read !== 1'b0) begin
            errors++; $display("FAIL fetch_single got ack=%b rd=%b exp 0 0", i_ack, read);
        end
    endtask

    task automatic test_store_wait();
        d_we = 1'b1; d_addr = 32'h1000; d_wdata = 32'hDEADBEEF; d_be = 4'b0011;
        waitrequest = 1'b1; d_req = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            step();
            checks++;
            if (write !== 1'b1 || read !== 1'b0 || address !== 32'h1000 || writedata !== 32'hDEADBEEF ||
                byteenable !== 4'b0011 || d_ack !== 1'b0) begin
                errors++; $display("FAIL store_hold c%0d got wr=%b rd=%b addr=%h wd=%h be=%h ack=%b exp 1 0 1000 deadbeef 3 0",
                                   c, write, read, address, writedata, byteenable, d_ack);
            end
            if (c == 4) waitrequest = 1'b0;
        end
        step();
        checks++;
        if (d_ack !== 1'b1 || write !== 1'b0 || read !== 1'b0 || d_rdata !== 32'h0) begin
            errors++; $display("FAIL store_ack got ack=%b wr=%b rd=%b drdata=%h exp 1 0 0 00000000",
                               d_ack, write, read, d_rdata);
        end
        d_req = 1'b0;
        step();
        checks++;
        if (d_ack !== 1'b0 || write !== 1'b0) begin
            errors++; $display("FAIL store_done got ack=%b wr=%b exp 0 0", d_ack, write);
        end
    endtask

    task automatic test_contention();
        bit rr_i = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        rr_i = 1'b1;
`endif
        do_reset();
        i_addr = 32'h40; d_addr = 32'h20; d_we = 1'b0; d_be = 4'h5;
        readdata = 32'hA5A50001; waitrequest = 1'b0; i_req = 1'b1; d_req = 1'b1;
        step();
        checks++;
        if (read !== 1'b1 || address !== 32'h20 || byteenable !== 4'h5) begin
            errors++; $display("FAIL tie1_d_first got rd=%b addr=%h be=%h exp 1 20 5", read, address, byteenable);
        end
        step();
        checks++;
        if (d_ack !== 1'b1 || i_ack !== 1'b0 || d_rdata !== 32'hA5A50001 || read !== 1'b0 || write !== 1'b0) begin
            errors++; $display("FAIL tie1_d_ack got dack=%b iack=%b drdata=%h rd=%b wr=%b exp 1 0 a5a50001 0 0",
                               d_ack, i_ack, d_rdata, read, write);
        end
        d_req = 1'b0; readdata = 32'h11112222;
        step();
        checks++;
        if (read !== 1'b1 || address !== 32'h40 || byteenable !== 4'hF) begin
            errors++; $display("FAIL tie1_i_next got rd=%b addr=%h be=%h exp 1 40 f", read, address, byteenable);
        end
        step();
        checks++;
        if (i_ack !== 1'b1 || i_rdata !== 32'h11112222) begin
            errors++; $display("FAIL tie1_i_ack got ack=%b rdata=%h exp 1 11112222", i_ack, i_rdata);
        end
        i_req = 1'b0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h24; d_wdata = 32'h0; d_be = 4'hF;
        step();
        step();
        checks++;
        if (d_ack !== 1'b1) begin
            errors++; $display("FAIL dsolo_ack got %b exp 1", d_ack);
        end
        d_req = 1'b0;
        step();
        i_req = 1'b1; i_addr = 32'h44; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h28;
        step();
        checks++;
        if (read !== 1'b1 || address !== (rr_i ? 32'h44 : 32'h28)) begin
            errors++; $display("FAIL tie2_winner got rd=%b addr=%h exp 1 %h", read, address, rr_i ? 32'h44 : 32'h28);
        end
        step();
        checks++;
        if ({i_ack, d_ack} !== (rr_i ? 2'b10 : 2'b01)) begin
            errors++; $display("FAIL tie2_ack1 got %b exp %b", {i_ack, d_ack}, rr_i ? 2'b10 : 2'b01);
        end
        if (i_ack) i_req = 1'b0;
        if (d_ack) d_req = 1'b0;
        step();
        checks++;
        if (read !== 1'b1 || address !== (rr_i ? 32'h28 : 32'h44)) begin
            errors++; $display("FAIL tie2_loser got rd=%b addr=%h exp 1 %h", read, address, rr_i ? 32'h28 : 32'h44);
        end
        step();
        checks++;
        if ({i_ack, d_ack} !== (rr_i ? 2'b01 : 2'b10)) begin
            errors++; $display("FAIL tie2_ack2 got %b exp %b", {i_ack, d_ack}, rr_i ? 2'b01 : 2'b10);
        end
        if (i_ack) i_req = 1'b0;
        if (d_ack) d_req = 1'b0;
        step();
    endtask

    task automatic test_ack_requeue();
        i_addr = 32'h80; readdata = 32'h0BADF00D; waitrequest = 1'b0; i_req = 1'b1;
        step();
        step();
        checks++;
        if (i_ack !== 1'b1 || i_rdata !== 32'h0BADF00D) begin
            errors++; $display("FAIL requeue_ack1 got ack=%b rdata=%h exp 1 0badf00d", i_ack, i_rdata);
        end
        step();
        checks++;
        if (read !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL requeue_nodup got rd=%b busy=%b exp 0 0", read, busy);
        end
        i_req = 1'b0;
        step();
        checks++;
        if (read !== 1'b0 || i_ack !== 1'b0) begin
            errors++; $display("FAIL requeue_quiet got rd=%b ack=%b exp 0 0", read, i_ack);
        end
        i_addr = 32'h84; readdata = 32'h12345678; i_req = 1'b1;
        step();
        step();
        checks++;
        if (i_ack !== 1'b1) begin
            errors++; $display("FAIL requeue_ack2 got %b exp 1", i_ack);
        end
        step();
        checks++;
        if (read !== 1'b0) begin
            errors++; $display("FAIL requeue_gap got rd=%b exp 0", read);
        end
        step();
        checks++;
        if (read !== 1'b1 || address !== 32'h84) begin
            errors++; $display("FAIL requeue_second got rd=%b addr=%h exp 1 84", read, address);
        end
        i_req = 1'b0;
        step();
        checks++;
        if (i_ack !== 1'b1 || i_rdata !== 32'h12345678) begin
            errors++; $display("FAIL requeue_ack3 got ack=%b rdata=%h exp 1 12345678", i_ack, i_rdata);
        end
        step();
    endtask

    task automatic test_random();
        logic [31:0]       mem [16];
        logic [31:0]       i_rd_model, d_rd_model, word;
        logic [ADDR_W-1:0] s_addr;
        logic [31:0]       s_wdata;
        logic [3:0]        s_be;
        logic              s_we;
        bit                s_d, act, i_el, d_el, pick_d;
        int                waits, n_done;
`ifdef ARB_ROUND_ROBIN_EN
        bit                last_d;
        last_d = 1'b0;
`endif
        act = 1'b0; i_el = 1'b0; d_el = 1'b0; waits = 0; n_done = 0;
        s_addr = '0; s_wdata = '0; s_be = '0; s_we = 1'b0; s_d = 1'b0;
        for (int k = 0; k < 16; k++) mem[k] = $urandom;
        do_reset();
        i_rd_model = '0; d_rd_model = '0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            step();
            if (act && !waitrequest) begin
                word = mem[s_addr[5:2]];
                checks++;
                if ({i_ack, d_ack} !== (s_d ? 2'b01 : 2'b10) || read !== 1'b0 || write !== 1'b0) begin
                    errors++; $display("FAIL rnd_ack cyc%0d got ack=%b rd=%b wr=%b exp ack=%b rd=0 wr=0",
                                       cyc, {i_ack, d_ack}, read, write, s_d ? 2'b01 : 2'b10);
                end
                if (s_we) begin
                    for (int b = 0; b < 4; b++) if (s_be[b]) word[8*b +: 8] = s_wdata[8*b +: 8];
                    mem[s_addr[5:2]] = word;
                end else if (s_d) begin
                    d_rd_model = word;
                end else begin
                    i_rd_model = word;
                end
                checks++;
                if (i_rdata !== i_rd_model || d_rdata !== d_rd_model) begin
                    errors++; $display("FAIL rnd_rdata cyc%0d got i=%h d=%h exp i=%h d=%h",
                                       cyc, i_rdata, d_rdata, i_rd_model, d_rd_model);
                end
                if (s_d) d_req = 1'b0; else i_req = 1'b0;
                act = 1'b0;
                n_done++;
            end else begin
                checks++;
                if (i_ack !== 1'b0 || d_ack !== 1'b0) begin
                    errors++; $display("FAIL rnd_spurious_ack cyc%0d got %b exp 00", cyc, {i_ack, d_ack});
                end
                if (!act && (i_el || d_el)) begin
`ifdef ARB_ROUND_ROBIN_EN
                    pick_d = d_el && (!i_el || !last_d);
                    last_d = pick_d;
`else
                    pick_d = d_el;
`endif
                    s_d     = pick_d;
                    s_addr  = pick_d ? d_addr : i_addr;
                    s_we    = pick_d ? d_we : 1'b0;
                    s_wdata = d_wdata;
                    s_be    = pick_d ? d_be : 4'hF;
                    act     = 1'b1;
                    waits   = $urandom_range(0, 3);
                end
                checks++;
                if (act) begin
                    if (read !== !s_we || write !== s_we || address !== s_addr || byteenable !== s_be ||
                        (s_we && writedata !== s_wdata)) begin
                        errors++; $display("FAIL rnd_bus cyc%0d got rd=%b wr=%b addr=%h be=%h wd=%h exp rd=%b wr=%b addr=%h be=%h wd=%h",
                                           cyc, read, write, address, byteenable, writedata, !s_we, s_we, s_addr, s_be, s_wdata);
                    end
                end else if (read !== 1'b0 || write !== 1'b0) begin
                    errors++; $display("FAIL rnd_idle cyc%0d got rd=%b wr=%b exp 0 0", cyc, read, write);
                end
            end
            checks++;
            if (busy !== act) begin
                errors++; $display("FAIL rnd_busy cyc%0d got %b exp %b", cyc, busy, act);
            end
            if (act) begin
                waitrequest = (waits > 0);
                if (waits > 0) waits--;
                readdata = waitrequest ? $urandom : mem[s_addr[5:2]];
            end else begin
                waitrequest = 1'($urandom_range(0, 1));
                readdata = $urandom;
            end
            if (!i_req && $urandom_range(0, 3) == 0) begin
                i_req = 1'b1;
                i_addr = 32'h100 + ($urandom_range(0, 15) << 2);
            end
            if (!d_req && $urandom_range(0, 3) == 0) begin
                d_req = 1'b1;
                d_we = 1'($urandom_range(0, 1));
                d_addr = 32'h100 + ($urandom_range(0, 15) << 2);
                d_wdata = $urandom;
                d_be = 4'($urandom_range(1, 15));
            end
            i_el = i_req && !i_ack;
            d_el = d_req && !d_ack;
        end
        checks++;
        if (n_done < 50 || err !== 1'b0) begin
            errors++; $display("FAIL rnd_progress got done=%0d err=%b exp >=50 0", n_done, err);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        i_addr = 32'hC0; readdata = 32'hFFFFFFFF; waitrequest = 1'b1; i_req = 1'b1;
        for (int c = 1; c <= TMO; c++) begin
            step();
            checks++;
            if (read !== 1'b1 || i_ack !== 1'b0 || err !== 1'b0) begin
                errors++; $display("FAIL tmo_stall c%0d got rd=%b ack=%b err=%b exp 1 0 0", c, read, i_ack, err);
            end
        end
        step();
        checks++;
        if (read !== 1'b0 || i_ack !== 1'b1 || err !== 1'b1 || i_rdata !== 32'h0) begin
            errors++; $display("FAIL tmo_abort got rd=%b ack=%b err=%b rdata=%h exp 0 1 1 00000000",
                               read, i_ack, err, i_rdata);
        end
        i_req = 1'b0; waitrequest = 1'b0;
        step();
        step();
        checks++;
        if (err !== 1'b1 || i_ack !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL tmo_sticky got err=%b ack=%b busy=%b exp 1 0 0", err, i_ack, busy);
        end
    endtask

    task automatic test_reset_mid();
        d_we = 1'b1; d_addr = 32'h30; d_wdata = 32'hCAFEF00D; d_be = 4'hF; waitrequest = 1'b1; d_req = 1'b1;
        step();
        checks++;
        if (write !== 1'b1) begin
            errors++; $display("FAIL rstmid_start got wr=%b exp 1", write);
        end
        reset = 1'b1;
        step();
        checks++;
        if (read !== 1'b0 || write !== 1'b0 || busy !== 1'b0 || d_ack !== 1'b0 || err !== 1'b0) begin
            errors++; $display("FAIL rstmid_abandon got rd=%b wr=%b busy=%b ack=%b err=%b exp 0 0 0 0 0",
                               read, write, busy, d_ack, err);
        end
        reset = 1'b0; d_req = 1'b0; waitrequest = 1'b0;
        step();
        checks++;
        if (d_ack !== 1'b0 || write !== 1'b0) begin
            errors++; $display("FAIL rstmid_noack got ack=%b wr=%b exp 0 0", d_ack, write);
        end
        i_addr = 32'h50; readdata = 32'h600DCAFE; i_req = 1'b1;
        step();
        checks++;
        if (read !== 1'b1 || address !== 32'h50) begin
            errors++; $display("FAIL rstmid_fetch got rd=%b addr=%h exp 1 50", read, address);
        end
        step();
        checks++;
        if (i_ack !== 1'b1 || i_rdata !== 32'h600DCAFE) begin
            errors++; $display("FAIL rstmid_fetch_ack got ack=%b rdata=%h exp 1 600dcafe", i_ack, i_rdata);
        end
        i_req = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store_wait();
        test_contention();
        test_ack_requeue();
        test_random();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single Avalon memory-mapped master port between two requesters inside the multicycle CPU: the instruction-fetch port (I, read-only) and the load/store data port (D).
- Registers each granted request, drives it onto the bus, and holds it until waitrequest drops.
- Returns read data and a one-cycle ack to the owning requester.
- Sits between the CPU control/datapath and the top-level bus pins.

Parameters:
TIMEOUT_CYCLES, 0, waitrequest-high cycles before a transaction is aborted; 0 disables the timeout
ADDR_W, 32, address width

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
i_req  in  1  fetch request; hold high until i_ack
i_addr  in  ADDR_W  fetch address
i_ack  out  1  one-cycle completion pulse for fetch
i_rdata  out  32  fetched word; valid while i_ack is high, held until the next I completion
d_req  in  1  data request; hold high until d_ack
d_we  in  1  1 = write, 0 = read
d_addr  in  ADDR_W  data address
d_wdata  in  32  store data
d_be  in  4  store/load byte enables
d_ack  out  1  one-cycle completion pulse for data
d_rdata  out  32  load word; valid while d_ack is high, held until the next D completion
address  out  ADDR_W  Avalon address
read  out  1  Avalon read
write  out  1  Avalon write
writedata  out  32  Avalon write data
byteenable  out  4  Avalon byte enables
waitrequest  in  1  Avalon stall
readdata  in  32  Avalon read data
busy  out  1  high in any state other than IDLE
err  out  1  sticky timeout flag

Behaviour:
- Interface decision: one clock, clk. Reset is synchronous and active-high on port reset.
- Reset values: state = IDLE; read, write, i_ack, d_ack, busy, err = 0; address, writedata, i_rdata, d_rdata = 0; byteenable = 0; timeout counter = 0. Reset asserted mid-transaction abandons it: read/write low after that edge, no ack issued.
- FSM states: IDLE, BUS_I, BUS_D.
- IDLE:
  - Samples i_req and d_req, but ignores the request of any port whose ack is high this cycle. This makes a requester that drops req on seeing ack safe.
  - Grant priority: D over I.
  - On grant, registers address, write data, byte enables and direction, then moves to BUS_I or BUS_D.
  - In BUS_I, byteenable = 4'hF and read = 1.
  - In BUS_D, read = !d_we and write = d_we.
- BUS_x:
  - Bus outputs are driven from registers and held stable while waitrequest = 1.
  - At the first posedge with waitrequest = 0: capture readdata into x_rdata (reads only), pulse x_ack for the next cycle, drop read/write, return to IDLE.
- Latency: req to ack is 2 cycles with zero wait states; each waitrequest cycle adds one.
- Turnaround: there is always one IDLE cycle between transactions, so read and write are never high in back-to-back cycles for different owners.
- Simultaneous i_req and d_req in IDLE: D granted. I stays pending, is granted in the following IDLE cycle, and is not starved beyond one D transaction when d_req drops on d_ack.
- Request changes in BUS_x have no effect; fields are latched at grant.
- Timeout (TIMEOUT_CYCLES > 0):
  - The counter increments each BUS_x cycle with waitrequest = 1.
  - On reaching TIMEOUT_CYCLES: drop read/write, pulse x_ack with x_rdata unchanged, set err, return to IDLE.
  - The counter clears on entry to BUS_x. err clears only on reset.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: fairness by last owner. When both requesters are pending in IDLE, the port that did not own the previous transaction wins. The last-owner bit resets to I, so D wins the first tie.
- Undefined: fixed D-over-I priority as above.

Decomposition:
- Package mem_bus_pkg holds:
  - arb_state_t enum {IDLE, BUS_I, BUS_D}
  - owner_t enum {OWN_I, OWN_D}
  - BYTE_ALL = 4'hF
- Sub-module bus_timeout_counter: clear, enable, limit, expired. Instantiated only when TIMEOUT_CYCLES > 0.

Test Plan:
- Fetch, zero wait: i_req = 1, i_addr = 32'hBFC00000, readdata = 32'h24020005 with waitrequest = 0 → read = 1 and address = BFC00000 at cycle 1; i_ack and i_rdata = 24020005 at cycle 2.
- Store with 3 wait states: d_we = 1, d_addr = 32'h1000, d_wdata = 32'hDEADBEEF, d_be = 4'b0011 → write, address, writedata and byteenable stable for 4 cycles; d_ack one cycle after waitrequest falls; read never high.
- Contention: i_req and d_req both high in IDLE → D serviced first, one IDLE cycle, then I. With ARB_ROUND_ROBIN_EN, a second tie is won by I.
- Timeout: TIMEOUT_CYCLES = 8 with waitrequest held at 1 → read drops after 8 stall cycles, i_ack pulses, err = 1 until reset.
- Reset mid-transaction: reset during BUS_D → read = write = 0 next cycle, no d_ack, state IDLE. A subsequent i_req completes normally.
- Ack/requeue: requester keeps i_req high in the cycle of i_ack → no duplicate transaction. Requester keeps i_req high one cycle longer → a second fetch is issued.
